// File: rtl/iic_arbiter.sv
// Round-robin arbiter in front of one shared I2C register-write master.
// Retries NACKed writes after a back-off gap and reports done/err per requester.
module iic_arbiter #(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [6:0] req0_slave,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_done,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [6:0] req1_slave,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       req1_err,
  output logic       m_valid,
  output logic [6:0] m_slave,
  output logic [7:0] m_reg,
  output logic [7:0] m_data,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       busy
);

  localparam int GW = $clog2(RETRY_GAP + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    BACKOFF,
    RESP
  } state_e;

  state_e        state_q;
  logic          last_q;
  logic          grant_q;
  logic          err_q;
  logic [3:0]    retry_q;
  logic [GW-1:0] gap_q;
  logic [6:0]    slave_q;
  logic [7:0]    reg_q;
  logic [7:0]    data_q;

  logic any_v;
  logic sel;
  logic idle;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_v = req0_valid | req1_valid;
    sel   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    idle  = (state_q == IDLE);
  end

  assign req0_ready = idle & any_v & ~sel & ~rst;
  assign req1_ready = idle & any_v & sel & ~rst;

  assign req0_done = (state_q == RESP) & ~grant_q;
  assign req1_done = (state_q == RESP) & grant_q;
  assign req0_err  = req0_done & err_q;
  assign req1_err  = req1_done & err_q;

  assign m_valid = (state_q == ISSUE);
  assign m_slave = slave_q;
  assign m_reg   = reg_q;
  assign m_data  = data_q;
  assign busy    = ~idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      retry_q <= '0;
      gap_q   <= '0;
      slave_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_v) begin
            grant_q <= sel;
            slave_q <= sel ? req1_slave : req0_slave;
            reg_q   <= sel ? req1_reg : req0_reg;
            data_q  <= sel ? req1_data : req0_data;
            retry_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            if (!m_nack) begin
              err_q   <= 1'b0;
              state_q <= RESP;
            end else if (retry_q < 4'(MAX_RETRY)) begin
              retry_q <= retry_q + 4'd1;
              gap_q   <= GW'(RETRY_GAP);
              state_q <= BACKOFF;
            end else begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        BACKOFF: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == GW'(1)) state_q <= ISSUE;
        end
        RESP: begin
          last_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: grant table plus
// hand sequences for retry, spurious done and reset.
module tb_iic_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_slave, req1_slave;
  logic [7:0] req0_reg, req1_reg;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req0_done, req0_err;
  logic       req1_ready, req1_done, req1_err;
  logic       m_valid;
  logic [6:0] m_slave;
  logic [7:0] m_reg, m_data;
  logic       m_ready, m_done, m_nack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  iic_arbiter #(.MAX_RETRY(2), .RETRY_GAP(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_slave(req0_slave),
    .req0_reg(req0_reg), .req0_data(req0_data),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_slave(req1_slave),
    .req1_reg(req1_reg), .req1_data(req1_data),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_err(req1_err),
    .m_valid(m_valid), .m_slave(m_slave),
    .m_reg(m_reg), .m_data(m_data),
    .m_ready(m_ready), .m_done(m_done), .m_nack(m_nack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_mv(output bit ok);
    int n = 0;
    while (!m_valid && n < 40) begin
      tick;
      n++;
    end
    ok = m_valid;
    chk("m_valid_timeout", {31'd0, m_valid}, 1);
  endtask

  task automatic accept;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  task automatic mdone(input logic nack);
    m_done = 1'b1;
    m_nack = nack;
    tick;
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return {m_valid, busy, req0_ready, req1_ready,
            req0_done, req1_done, req0_err, req1_err,
            m_slave, m_reg, m_data};
  endfunction

  initial begin
    bit ok;
    int n;
    int issues;
    int extra;

    vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vec[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    {req0_valid, req1_valid} = '0;
    {req0_slave, req0_reg, req0_data} = '0;
    {req1_slave, req1_reg, req1_data} = '0;
    {m_ready, m_done, m_nack} = '0;
    tick;
    tick;
    chk("reset_outputs", all_out(), 0);
    rst = 1'b0;

    // Combinational grant from the reset state (last_grant = 1).
    for (int i = 0; i < 4; i++) begin
      req0_valid = vec[i].v0;
      req1_valid = vec[i].v1;
      #1;
      chk($sformatf("grant_vec%0d", i),
          {30'd0, req0_ready, req1_ready},
          {30'd0, vec[i].r0, vec[i].r1});
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;
    end
    chk("table_idle", {31'd0, busy}, 0);

    // Single write.
    {req0_slave, req0_reg, req0_data} = {7'h76, 8'h41, 8'h10};
    req0_valid = 1'b1;
    #1;
    chk("single_ready", {30'd0, req0_ready, req1_ready}, 2'b10);
    tick;
    req0_valid = 1'b0;
    chk("single_issue", {m_valid, busy, req0_ready, m_slave, m_reg, m_data},
        {1'b1, 1'b1, 1'b0, 7'h76, 8'h41, 8'h10});
    accept;
    chk("single_wait", {30'd0, m_valid, busy}, 2'b01);
    repeat (49) tick;
    mdone(1'b0);
    chk("single_done", {29'd0, req0_done, req0_err, req1_done}, 3'b100);
    tick;
    chk("single_after", {30'd0, req0_done, busy}, 2'b00);

    // Tie and fairness from a fresh reset.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    {req0_slave, req0_reg, req0_data} = {7'h10, 8'h01, 8'haa};
    {req1_slave, req1_reg, req1_data} = {7'h20, 8'h02, 8'hbb};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_mv(ok);
      chk($sformatf("fair_order%0d", i), {25'd0, m_slave},
          (i % 2) ? 32'h20 : 32'h10);
      accept;
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      mdone(1'b0);
      chk($sformatf("fair_done%0d", i), {30'd0, req0_done, req1_done},
          (i % 2) ? 32'd1 : 32'd2);
    end
    tick;
    chk("fair_idle", {31'd0, busy}, 0);

    // NACK then success, with a stray m_done during back-off.
    {req1_slave, req1_reg, req1_data} = {7'h30, 8'h03, 8'hcc};
    req1_valid = 1'b1;
    wait_mv(ok);
    req1_valid = 1'b0;
    chk("nack_fields1", {m_slave, m_reg, m_data}, {7'h30, 8'h03, 8'hcc});
    accept;
    mdone(1'b1);
    n = 1;
    while (!m_valid && n < 40) begin
      if (n == 3) m_done = 1'b1;
      tick;
      m_done = 1'b0;
      n++;
    end
    chk("nack_gap", n, 11);
    chk("nack_fields2", {m_slave, m_reg, m_data}, {7'h30, 8'h03, 8'hcc});
    accept;
    mdone(1'b0);
    chk("nack_done", {29'd0, req1_done, req1_err, req0_done}, 3'b100);
    tick;

    // Spurious m_done in IDLE.
    m_done = 1'b1;
    m_nack = 1'b1;
    tick;
    m_done = 1'b0;
    m_nack = 1'b0;
    chk("spur_idle", {29'd0, busy, req0_done, req1_done}, 0);

    // Retries exhausted; stray m_done while waiting for m_ready.
    {req0_slave, req0_reg, req0_data} = {7'h40, 8'h04, 8'hdd};
    req0_valid = 1'b1;
    issues = 0;
    for (int i = 0; i < 3; i++) begin
      wait_mv(ok);
      if (i == 0) begin
        req0_valid = 1'b0;
        m_done = 1'b1;
        tick;
        m_done = 1'b0;
        chk("spur_issue", {29'd0, m_valid, busy, req0_done}, 3'b110);
      end
      if (ok) issues++;
      accept;
      mdone(1'b1);
      if (i < 2)
        chk($sformatf("exh_nodone%0d", i), {30'd0, req0_done, busy}, 2'b01);
    end
    chk("exh_issues", issues, 3);
    chk("exh_done", {29'd0, req0_done, req0_err, req1_done}, 3'b110);
    tick;
    chk("exh_pulse", {30'd0, req0_done, req0_err}, 0);
    extra = 0;
    repeat (20) begin
      if (m_valid) extra++;
      tick;
    end
    chk("exh_no_reissue", extra, 0);

    // Asynchronous reset in WAIT.
    {req0_slave, req0_reg, req0_data} = {7'h50, 8'h05, 8'hee};
    req0_valid = 1'b1;
    wait_mv(ok);
    req0_valid = 1'b0;
    accept;
    tick;
    {req1_slave, req1_reg, req1_data} = {7'h60, 8'h06, 8'h11};
    req1_valid = 1'b1;
    chk("rstw_pre", {30'd0, m_valid, busy}, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rstw_outputs", all_out(), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rstw_grant1", {30'd0, req0_ready, req1_ready}, 2'b01);
    tick;
    req1_valid = 1'b0;
    chk("rstw_issue", {m_valid, m_slave, m_reg, m_data},
        {1'b1, 7'h60, 8'h06, 8'h11});

    // Asynchronous reset in BACKOFF; the aborted write is dropped.
    accept;
    mdone(1'b1);
    tick;
    #2 rst = 1'b1;
    #1;
    chk("rstb_outputs", all_out(), 0);
    tick;
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      if (m_valid || busy || req1_done) extra++;
      tick;
    end
    chk("rstb_lost", extra, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
